// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style front end.
//   fetch_state_t     : fetch FSM states (IDLE, REQ, WAIT, HOLD)
//   RESET_PC_DEFAULT  : default PC loaded on reset
//   OP_*              : primary opcode field values, shared with the main decoder
//   sign_ext16        : sign-extends a 16-bit immediate to 32 bits
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/fetch_unit_pc_next.sv
// pc_next: combinational next-PC selection for the fetch unit.
// Ports:
//   pc        in  32  current PC
//   instr_idx in  26  low 26 bits of the held instruction (jump index / imm16)
//   branch    in  1   decoder says conditional branch
//   ne        in  1   branch sense: 0 = BEQ, 1 = BNE
//   jump      in  1   decoder says unconditional jump
//   zero      in  1   ALU zero flag
//   pcplus4   out 32  pc + 4 (mod 2^32)
//   npc       out 32  selected next PC: jump > taken branch > pc + 4
module pc_next
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr_idx,
  input  logic        branch,
  input  logic        ne,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] pcplus4,
  output logic [31:0] npc
);

  logic [31:0] br_target;
  logic [31:0] j_target;
  logic        taken;

  always_comb begin
    pcplus4   = pc + 32'd4;
    br_target = pcplus4 + (sign_ext16(instr_idx[15:0]) << 2);
    // Jumps stay inside the 256 MB region of the delay-slot address.
    j_target  = {pcplus4[31:28], instr_idx, 2'b00};
    // zero ^ ne: BEQ takes on zero, BNE takes on non-zero.
    taken     = branch & (zero ^ ne);
    if (jump) begin
      npc = j_target;
    end else if (taken) begin
      npc = br_target;
    end else begin
      npc = pcplus4;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with a held instruction
// register, PC update on retirement and a retired-instruction counter.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   imem_req/imem_addr      fetch request and byte address (addr == pc)
//   imem_ready              memory accepts the request this cycle
//   imem_rvalid/imem_rdata  response strobe and instruction word
//   instr/instr_valid       held instruction and its valid flag
//   instr_ack               held instruction retires this cycle
//   branch/ne/jump/zero     control for the held instruction, valid with ack
//   pc/pcplus4              current PC and PC + 4
//   retired                 retired-instruction count (wraps)
//   fsm_state               current fetch FSM state, for observation
//
// Handshake: a fetch is accepted on the cycle imem_req && imem_ready. Its
// data arrives on the first later-or-same cycle with imem_rvalid, and only
// while the fetch is outstanding (REQ after acceptance, or WAIT); any other
// imem_rvalid is ignored. The held instruction is consumed on the cycle
// instr_valid && instr_ack; instr_ack without instr_valid is ignored.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
  // Count loaded on reset; 0 for normal operation.
  parameter logic [31:0] RETIRED_INIT = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ready,
  input  logic         imem_rvalid,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  instr,
  output logic         instr_valid,
  input  logic         instr_ack,
  input  logic         branch,
  input  logic         ne,
  input  logic         jump,
  input  logic         zero,
  output logic [31:0]  pc,
  output logic [31:0]  pcplus4,
  output logic [31:0]  retired,
  output fetch_state_t fsm_state
);

  // Keep the PC word aligned even if an unaligned reset value is given.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  retired_q, retired_d;
  logic [31:0]  npc;

  pc_next u_pc_next (
    .pc        (pc_q),
    .instr_idx (instr_q[25:0]),
    .branch    (branch),
    .ne        (ne),
    .jump      (jump),
    .zero      (zero),
    .pcplus4   (pcplus4),
    .npc       (npc)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    retired_d   = retired_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          if (imem_rvalid) begin
            instr_d = imem_rdata;
            state_d = HOLD;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (instr_ack) begin
          pc_d      = npc;
          retired_d = retired_q + 32'd1;
          state_d   = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC_ALIGNED;
      instr_q   <= 32'h0000_0000;
      retired_q <= RETIRED_INIT;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign pc        = pc_q;
  assign retired   = retired_q;
  assign fsm_state = state_q;

endmodule
